// File: rtl/sub_tree_unpack.sv
// sub_tree_unpack: recovers ss2 = s - ss1, b = ss1 - a and d = ss2 - c from the adder-tree total.
// Latency: a packet accepted in cycle N produces out_valid in cycle N+4. At most one packet every 5 cycles.
// Backpressure: in_ready is registered and high only in IDLE. A result is held stable in OUT until out_ready.
//
// Optional statistics counter: define SUB_TREE_STATS_EN to add the pkt_count output.
//
// Ports:
//   clk, rst                      clock and synchronous active-high reset
//   in_valid / in_ready           input handshake (in_ready registered)
//   in_s, in_ss1, in_data_a,      packet fields: tree total, partial sum a+b,
//   in_data_c                     and the two known operands a and c
//   out_valid / out_ready         output handshake
//   out_ss2, out_data_b,          recovered c+d, b and d (all modulo 2^W)
//   out_data_d
//   pkt_count                     (SUB_TREE_STATS_EN only) number of delivered results, wraps at 256
module sub_tree_unpack #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_s,
    input  logic [W-1:0] in_ss1,
    input  logic [W-1:0] in_data_a,
    input  logic [W-1:0] in_data_c,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_ss2,
    output logic [W-1:0] out_data_b,
    output logic [W-1:0] out_data_d
`ifdef SUB_TREE_STATS_EN
    ,
    output logic [7:0]   pkt_count
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SUB_SS2 = 3'd1,
        ST_SUB_B   = 3'd2,
        ST_SUB_D   = 3'd3,
        ST_OUT     = 3'd4
    } state_t;

    state_t state_q, state_d;

    logic         in_ready_q, in_ready_d;
    logic         out_valid_q, out_valid_d;

    // Captured packet fields and intermediate results
    logic [W-1:0] s_q, ss1_q, a_q, c_q;
    logic [W-1:0] ss2_q, b_q;

    // Output registers, loaded once per packet in SUB_D
    logic [W-1:0] out_ss2_q, out_b_q, out_d_q;

    // The single shared subtractor
    logic [W-1:0] sub_x, sub_y, sub_res;

    logic         accept;
    logic         out_fire;

    assign accept   = in_valid && in_ready_q;
    assign out_fire = out_valid_q && out_ready;

    // ---------------------------------------------------------------
    // FSM state register
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    // ---------------------------------------------------------------
    // FSM next-state logic
    // ---------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:    if (accept) state_d = ST_SUB_SS2;
            ST_SUB_SS2: state_d = ST_SUB_B;
            ST_SUB_B:   state_d = ST_SUB_D;
            ST_SUB_D:   state_d = ST_OUT;
            ST_OUT:     if (out_ready) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
        // The handshake flags are registered copies of the next state, so
        // neither port sees a combinational path from the other side.
        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_OUT);
    end

    // ---------------------------------------------------------------
    // Subtractor operand select: one difference per SUB_* state
    // ---------------------------------------------------------------
    always_comb begin
        sub_x = s_q;
        sub_y = ss1_q;
        case (state_q)
            ST_SUB_B: begin
                sub_x = ss1_q;
                sub_y = a_q;
            end
            ST_SUB_D: begin
                sub_x = ss2_q;
                sub_y = c_q;
            end
            default: begin
                sub_x = s_q;
                sub_y = ss1_q;
            end
        endcase
    end

    // Borrow is discarded: the W-bit result is the difference modulo 2^W.
    assign sub_res = sub_x - sub_y;

    // ---------------------------------------------------------------
    // Datapath registers
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            s_q       <= '0;
            ss1_q     <= '0;
            a_q       <= '0;
            c_q       <= '0;
            ss2_q     <= '0;
            b_q       <= '0;
            out_ss2_q <= '0;
            out_b_q   <= '0;
            out_d_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // Fields are sampled only on the accepting edge.
                    if (accept) begin
                        s_q   <= in_s;
                        ss1_q <= in_ss1;
                        a_q   <= in_data_a;
                        c_q   <= in_data_c;
                    end
                end
                ST_SUB_SS2: ss2_q <= sub_res;
                ST_SUB_B:   b_q   <= sub_res;
                ST_SUB_D: begin
                    // d goes straight into the output register; it has no
                    // other consumer.
                    out_ss2_q <= ss2_q;
                    out_b_q   <= b_q;
                    out_d_q   <= sub_res;
                end
                default: ;
            endcase
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_ss2    = out_ss2_q;
    assign out_data_b = out_b_q;
    assign out_data_d = out_d_q;

`ifdef SUB_TREE_STATS_EN
    logic [7:0] pkt_count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_count_q <= 8'd0;
        end else if (out_fire) begin
            pkt_count_q <= pkt_count_q + 8'd1;
        end
    end

    assign pkt_count = pkt_count_q;
`else
    logic unused_fire;
    assign unused_fire = out_fire;
`endif

endmodule

// File: tb/tb_sub_tree_unpack.sv
module tb_sub_tree_unpack;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_s, in_ss1, in_data_a, in_data_c;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_ss2, out_data_b, out_data_d;
`ifdef SUB_TREE_STATS_EN
    logic [7:0]   pkt_count;
`endif

    int checks;
    int errors;

    sub_tree_unpack #(.W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_s       (in_s),
        .in_ss1     (in_ss1),
        .in_data_a  (in_data_a),
        .in_data_c  (in_data_c),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_ss2    (out_ss2),
        .out_data_b (out_data_b),
        .out_data_d (out_data_d)
`ifdef SUB_TREE_STATS_EN
        ,
        .pkt_count  (pkt_count)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one clock; sample/drive 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for in_ready, present one packet for exactly one accepting edge.
    task automatic send(input logic [W-1:0] s, input logic [W-1:0] ss1,
                        input logic [W-1:0] a, input logic [W-1:0] c);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout in_ready=%0b required=1", in_ready);
        end
        in_valid  = 1'b1;
        in_s      = s;
        in_ss1    = ss1;
        in_data_a = a;
        in_data_c = c;
        tick();
        in_valid  = 1'b0;
    endtask

    // Called just after the accepting edge; returns the cycle at which out_valid rose
    // (1 = the cycle right after the accepting edge). Bounded at 20.
    task automatic wait_valid(output int lat);
        lat = 1;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b1;   // rst must win over a pending handshake
        out_ready = 1'b1;
        in_s = 4'd5; in_ss1 = 4'd1; in_data_a = 4'd1; in_data_c = 4'd1;
        tick();
        tick();
        in_valid = 1'b0;
        rst      = 1'b0;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
        checks++; if ({out_ss2, out_data_b, out_data_d} !== 12'h000) begin
            errors++; $display("FAIL reset_outputs got=%h exp=000", {out_ss2, out_data_b, out_data_d});
        end
`ifdef SUB_TREE_STATS_EN
        checks++; if (pkt_count !== 8'd0) begin errors++; $display("FAIL reset_pkt_count got=%0d exp=0", pkt_count); end
`endif
        // out_ready high with nothing valid must not produce anything
        repeat (3) tick();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL idle_out_ready got valid=%0b rdy=%0b exp valid=0 rdy=1", out_valid, in_ready);
        end
    endtask

    task automatic test_basic();
        int lat;
        out_ready = 1'b1;
        send(4'd10, 4'd3, 4'd1, 4'd2);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL basic_busy in_ready got=%0b exp=0", in_ready); end
        wait_valid(lat);
        checks++; if (lat !== 4) begin errors++; $display("FAIL basic_latency got=%0d exp=4", lat); end
        checks++; if (out_ss2 !== 4'd7) begin errors++; $display("FAIL basic_ss2 got=%0d exp=7", out_ss2); end
        checks++; if (out_data_b !== 4'd2) begin errors++; $display("FAIL basic_b got=%0d exp=2", out_data_b); end
        checks++; if (out_data_d !== 4'd5) begin errors++; $display("FAIL basic_d got=%0d exp=5", out_data_d); end
        tick();
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL basic_return got rdy=%0b valid=%0b exp rdy=1 valid=0", in_ready, out_valid);
        end
    endtask

    task automatic test_wrap();
        int lat;
        out_ready = 1'b1;
        send(4'd2, 4'd9, 4'd12, 4'd15);
        wait_valid(lat);
        checks++; if (lat !== 4) begin errors++; $display("FAIL wrap_latency got=%0d exp=4", lat); end
        checks++; if ({out_ss2, out_data_b, out_data_d} !== {4'd9, 4'd13, 4'd10}) begin
            errors++; $display("FAIL wrap_results got ss2=%0d b=%0d d=%0d exp ss2=9 b=13 d=10",
                               out_ss2, out_data_b, out_data_d);
        end
        tick();
    endtask

    task automatic test_backpressure();
        int lat;
        out_ready = 1'b0;
        send(4'd13, 4'd5, 4'd4, 4'd6);   // ss2=8 b=1 d=2
        // next packet waits at the input for the whole stall
        in_valid = 1'b1;
        in_s = 4'd3; in_ss1 = 4'd7; in_data_a = 4'd7; in_data_c = 4'd8;  // ss2=12 b=0 d=4
        wait_valid(lat);
        checks++; if (lat !== 4) begin errors++; $display("FAIL bp_latency got=%0d exp=4", lat); end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
                {out_ss2, out_data_b, out_data_d} !== {4'd8, 4'd1, 4'd2}) begin
                errors++;
                $display("FAIL bp_hold cycle=%0d got valid=%0b rdy=%0b ss2=%0d b=%0d d=%0d exp valid=1 rdy=0 ss2=8 b=1 d=2",
                         i, out_valid, in_ready, out_ss2, out_data_b, out_data_d);
            end
            tick();
        end
        out_ready = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_release got valid=%0b rdy=%0b exp valid=0 rdy=1", out_valid, in_ready);
        end
        tick();   // waiting packet is accepted on this edge
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_second_accept in_ready got=%0b exp=0", in_ready); end
        wait_valid(lat);
        checks++; if ({out_ss2, out_data_b, out_data_d} !== {4'd12, 4'd0, 4'd4}) begin
            errors++; $display("FAIL bp_second_results got ss2=%0d b=%0d d=%0d exp ss2=12 b=0 d=4",
                               out_ss2, out_data_b, out_data_d);
        end
        tick();
    endtask

    task automatic test_busy_ignore();
        int lat;
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_s = 4'd9; in_ss1 = 4'd4; in_data_a = 4'd1; in_data_c = 4'd3;   // ss2=5 b=3 d=2
        tick();
        // change fields while busy, keep in_valid asserted
        in_s = 4'd14; in_ss1 = 4'd6; in_data_a = 4'd2; in_data_c = 4'd3;  // ss2=8 b=4 d=5
        wait_valid(lat);
        checks++; if (lat !== 4) begin errors++; $display("FAIL busy_latency got=%0d exp=4", lat); end
        checks++; if ({out_ss2, out_data_b, out_data_d} !== {4'd5, 4'd3, 4'd2}) begin
            errors++; $display("FAIL busy_first got ss2=%0d b=%0d d=%0d exp ss2=5 b=3 d=2",
                               out_ss2, out_data_b, out_data_d);
        end
        tick();
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL busy_idle got rdy=%0b valid=%0b exp rdy=1 valid=0", in_ready, out_valid);
        end
        tick();
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL busy_second_accept in_ready got=%0b exp=0", in_ready); end
        wait_valid(lat);
        checks++; if ({out_ss2, out_data_b, out_data_d} !== {4'd8, 4'd4, 4'd5}) begin
            errors++; $display("FAIL busy_second got ss2=%0d b=%0d d=%0d exp ss2=8 b=4 d=5",
                               out_ss2, out_data_b, out_data_d);
        end
        tick();
    endtask

    task automatic test_reset_midop();
        int lat;
        out_ready = 1'b1;
        send(4'd10, 4'd3, 4'd1, 4'd2);
        tick();            // now in SUB_B
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL midrst_flags got valid=%0b rdy=%0b exp valid=0 rdy=1", out_valid, in_ready);
        end
        checks++; if ({out_ss2, out_data_b, out_data_d} !== 12'h000) begin
            errors++; $display("FAIL midrst_outputs got=%h exp=000", {out_ss2, out_data_b, out_data_d});
        end
        // the discarded packet must not surface later
        repeat (5) tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_discard out_valid got=%0b exp=0", out_valid); end
        send(4'd15, 4'd15, 4'd0, 4'd0);
        wait_valid(lat);
        checks++; if (lat !== 4) begin errors++; $display("FAIL midrst_latency got=%0d exp=4", lat); end
        checks++; if ({out_ss2, out_data_b, out_data_d} !== {4'd0, 4'd15, 4'd0}) begin
            errors++; $display("FAIL midrst_results got ss2=%0d b=%0d d=%0d exp ss2=0 b=15 d=0",
                               out_ss2, out_data_b, out_data_d);
        end
        tick();
    endtask

`ifdef SUB_TREE_STATS_EN
    task automatic test_stats();
        int lat;
        out_ready = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 257; i++) begin
            send(4'(i), 4'(i + 3), 4'd1, 4'd2);
            wait_valid(lat);
            tick();
        end
        checks++; if (pkt_count !== 8'd1) begin errors++; $display("FAIL stats_wrap got=%0d exp=1", pkt_count); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (pkt_count !== 8'd0) begin errors++; $display("FAIL stats_clear got=%0d exp=0", pkt_count); end
    endtask
`endif

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_s      = '0;
        in_ss1    = '0;
        in_data_a = '0;
        in_data_c = '0;

        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_busy_ignore();
        test_reset_midop();
`ifdef SUB_TREE_STATS_EN
        test_stats();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
